// File: rtl/adc_sample_buffer_if.sv
// Simple register bus (write/read address, data and strobes) used by software
// to configure the sample buffer and drain its FIFO.
interface adc_sample_buffer_if #(
   parameter int ADDR_W = 6,
   parameter int BUS_W  = 32
);
   logic [ADDR_W-1:0] wrAddr;
   logic [BUS_W-1:0]  wrData;
   logic              wr;
   logic [ADDR_W-1:0] rdAddr;
   logic [BUS_W-1:0]  rdData;
   logic              rd;

   modport master (
      output wrAddr, wrData, wr, rdAddr, rd,
      input  rdData
   );

   modport slave (
      input  wrAddr, wrData, wr, rdAddr, rd,
      output rdData
   );
endinterface

// File: rtl/adc_sample_buffer.sv
// Collects ADC conversion results, optionally averages 2^k of them, and queues
// the results in a FIFO that software drains through the simple register bus.
module adc_sample_buffer #(
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int DATA_W             = 16,
   parameter int DEPTH_LOG2         = 4
) (
   input  logic              S_AXI_ACLK,
   input  logic              S_AXI_ARESETN,
   adc_sample_buffer_if.slave bus,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic              data_ready
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int ACC_W = DATA_W + 4;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_CTRL   = C_S_AXI_ADDR_WIDTH'(0);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_STATUS = C_S_AXI_ADDR_WIDTH'(1);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_DATA   = C_S_AXI_ADDR_WIDTH'(2);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_FLUSH  = C_S_AXI_ADDR_WIDTH'(3);

   function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                   input logic [2:0] k);
      logic [ACC_W-1:0] shifted;
      shifted = sum >> k;
      return shifted[DATA_W-1:0];
   endfunction

   logic [3:0]            ctrl_q, ctrl_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [4:0]            scnt_q, scnt_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_W-1:0]     mem_q [DEPTH];

   logic                  wr_ctrl, wr_status, wr_flush;
   logic                  empty, full, enable;
   logic [2:0]            k, wr_k;
   logic [4:0]            scnt_last;
   logic [ACC_W-1:0]      sum;
   logic                  s_take, push_req, pop_req, push_ok, pop_ok;
   logic [DATA_W-1:0]     push_val;

   assign enable    = ctrl_q[0];
   assign k         = ctrl_q[3:1];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign wr_ctrl   = bus.wr && (bus.wrAddr == A_CTRL);
   assign wr_status = bus.wr && (bus.wrAddr == A_STATUS);
   assign wr_flush  = bus.wr && (bus.wrAddr == A_FLUSH);
   assign wr_k      = (bus.wrData[3:1] > 3'd4) ? 3'd4 : bus.wrData[3:1];
   assign scnt_last = 5'((5'd1 << k) - 5'd1);
   assign sum       = acc_q + ACC_W'(sample_data);
   assign push_val  = avg_trunc(sum, k);

   // Samples coinciding with a CTRL or FLUSH write are discarded.
   assign s_take   = sample_valid && enable && !wr_ctrl && !wr_flush;
   assign push_req = s_take && (scnt_q == scnt_last);
   assign pop_req  = bus.rd && (bus.rdAddr == A_DATA) && !empty;
   assign push_ok  = push_req && (!full || pop_req);
   assign pop_ok   = pop_req && !wr_flush;

   always_comb begin
      ctrl_d  = ctrl_q;
      acc_d   = acc_q;
      scnt_d  = scnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      if (wr_ctrl) begin
         ctrl_d = {wr_k, bus.wrData[0]};
         acc_d  = '0;
         scnt_d = '0;
      end else if (wr_flush) begin
         acc_d  = '0;
         scnt_d = '0;
      end else if (s_take) begin
         if (push_req) begin
            acc_d  = '0;
            scnt_d = '0;
         end else begin
            acc_d  = sum;
            scnt_d = scnt_q + 5'd1;
         end
      end

      if (wr_status && bus.wrData[10]) ovf_d = 1'b0;
      if (push_req && !push_ok) ovf_d = 1'b1;

      if (wr_flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok) rptr_d = rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ctrl_q  <= '0;
         acc_q   <= '0;
         scnt_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         acc_q   <= acc_d;
         scnt_q  <= scnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage is data only; entries are qualified by the pointers and count.
   always_ff @(posedge S_AXI_ACLK) begin
      if (push_ok && !wr_flush) mem_q[wptr_q] <= push_val;
   end

   always_comb begin
      bus.rdData = '0;
      case (bus.rdAddr)
         A_CTRL:   bus.rdData[3:0] = ctrl_q;
         A_STATUS: begin
            bus.rdData[DEPTH_LOG2:0] = count_q;
            bus.rdData[8]            = empty;
            bus.rdData[9]            = full;
            bus.rdData[10]           = ovf_q;
         end
         A_DATA: begin
            if (!empty) begin
               bus.rdData[C_S_AXI_DATA_WIDTH-1] = 1'b1;
               bus.rdData[DATA_W-1:0]           = mem_q[rptr_q];
            end
         end
         default: bus.rdData = '0;
      endcase
   end

   assign data_ready = !empty;

   logic unused_wrdata;
   assign unused_wrdata = ^{bus.wrData[C_S_AXI_DATA_WIDTH-1:11], bus.wrData[9:4]};
endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
- Downstream consumer of the SPI ADC/DAC controller.
- Takes each completed conversion result (one-cycle valid pulse plus data), optionally averages N = 2^k results, and queues them in a FIFO.
- Software drains the FIFO through the same simple register bus (wrAddr/wrData/wr/rdAddr/rdData/rd) that the Axi4LiteSupporter produces.
- Removes the need for the CPU to poll each conversion's done bit.

Parameters:
- C_S_AXI_ADDR_WIDTH, 6, simple-bus address width.
- C_S_AXI_DATA_WIDTH, 32, simple-bus data width.
- DATA_W, 16, sample width (max 24).
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 = 16 entries.

Ports:
- S_AXI_ACLK  in  1  sole clock, rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- wrAddr  in  C_S_AXI_ADDR_WIDTH  register write address.
- wrData  in  C_S_AXI_DATA_WIDTH  register write data.
- wr  in  1  one-cycle write strobe.
- rdAddr  in  C_S_AXI_ADDR_WIDTH  register read address.
- rdData  out  C_S_AXI_DATA_WIDTH  combinational read data for rdAddr.
- rd  in  1  one-cycle read strobe.
- sample_valid  in  1  one-cycle pulse, conversion complete.
- sample_data  in  DATA_W  conversion result, valid with sample_valid.
- data_ready  out  1  high while FIFO not empty (interrupt source).

Behaviour:
- Reset (async, ARESETN low), all zero: FIFO pointers, count, accumulator, sample counter, CTRL, overflow flag. Outputs: data_ready=0, rdData = 0 for addr 0 and addr 2, and status for addr 1 (empty bit set).
- Register map, word index on wrAddr/rdAddr:
  - 0 CTRL (R/W): bit0 enable, bits[3:1] avg_log2 k. k>4 is clamped to 4.
  - 1 STATUS (R): [DEPTH_LOG2:0] count, bit8 empty, bit9 full, bit10 overflow (sticky). Write with bit10=1 clears overflow.
  - 2 DATA (R): bit31 valid, [DATA_W-1:0] FIFO head.
  - 3 FLUSH (W, any data): empties FIFO and clears accumulator. Overflow is not cleared.
  - Unmapped reads return 0; unmapped writes are ignored.
- Accumulator: acc is DATA_W+4 bits unsigned; scnt is 5 bits.
  - On sample_valid with enable=1: if scnt == 2^k-1, push (acc+sample_data)>>k truncated to DATA_W, then acc=0, scnt=0. Otherwise acc += sample_data, scnt++.
  - k=0: every sample pushed unmodified, same edge.
  - sample_valid with enable=0 is ignored.
- Latency: sample_valid at edge n → entry visible in count/rdData/data_ready after edge n (one cycle).
- Pop: rd && rdAddr==2 at edge n returns the pre-pop head on rdData (combinational) and advances the read pointer at edge n. Pop when empty returns 0 (valid bit 0) and has no state change.
- Push when full without a simultaneous pop: sample dropped, overflow set, pointers unchanged.
- Simultaneous push and pop:
  - Both occur and count is unchanged, including when full (no overflow) and when count=1.
  - When empty, the pop is a no-op and the push lands (count becomes 1).
- Pointers wrap modulo 2^DEPTH_LOG2; count is DEPTH_LOG2+1 bits and ranges 0..16.
- Any CTRL write clears acc and scnt. A sample_valid in the same cycle as a CTRL or FLUSH write is discarded. FLUSH wins over a same-cycle push or pop.
- Reset mid-accumulation or mid-drain discards everything; no partial average is pushed.

Test Plan:
- Reset → rdData@1 = 0x100 (empty), data_ready=0. CTRL=0x1 (k=0); pulse samples 0x1234 then 0xABCD → count=2. Read addr2 twice → 0x80001234, then 0x8000ABCD, data_ready=0.
- CTRL=0x5 (k=2); samples 10, 20, 30, 41 → exactly one entry, value 25 (101>>2). Only 3 samples → count stays 0.
- k=0: push 17 samples with no reads → count=16, full=1, overflow=1, and the 17th sample is absent on drain. Write STATUS 0x400 → overflow=0.
- FIFO full: sample_valid and DATA read in the same cycle → returns oldest entry, count stays 16, overflow stays 0.
- Read addr2 when empty → 0x00000000, pointers unchanged. FLUSH with 5 entries and a same-cycle sample → count=0.
- k=4 after 7 samples, assert ARESETN low for one cycle → count=0, acc cleared. The next 16 samples of 0xFFFF push 0xFFFF (no truncation error).
